hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised RAW-hazard scoreboard for the pipelined rv32i core; successor to the single-cycle datapath, where load self-dependencies such as `lw x10, 4(x10)` resolved trivially. Sits beside the decode stage. Tracks destination registers of in-flight instructions through `STAGES` downstream pipeline stages. From these it produces the decode stall, the forwarding selects for rs1/rs2, and a stall-cycle performance counter.

## Interface
- `STAGES`, 3: number of pipeline stages after ID (stage 1 = EX … stage `STAGES` = WB); ≥1.
- `ALU_READY`, 2: first stage whose entry can forward a non-load result; 1 ≤ `ALU_READY` ≤ `LOAD_READY`.
- `LOAD_READY`, 3: first stage whose entry can forward a load result; ≤ `STAGES`.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode holds a real instruction.
- `id_rs1_addr`, `id_rs2_addr`  in  `REG_ADDR_WIDTH`  source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1  source is actually read by the opcode.
- `id_rd_addr`  in  `REG_ADDR_WIDTH`  destination register.
- `id_reg_write`  in  1  instruction writes rd (control `reg_write`).
- `id_mem_read`  in  1  instruction is a load (control `mem_read`).
- `flush`  in  1  kill all in-flight entries (taken branch/jump).
- `stall`  out  1  hold PC and the ID register, and insert a bubble into stage 1.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  `$clog2(STAGES+1)`  0 = register file; k = forward from stage k.
- `stall_count`  out  16  saturating count of stall cycles.

## Operation
- Entry per stage: `valid`, `rd`, `is_load`.
- On every clock, entries shift from stage k to k+1, and stage `STAGES` retires.
- Stage 1 loads the ID instruction when `id_valid & ~stall`. `valid = id_reg_write & (id_rd_addr != 0)`. Otherwise stage 1 loads a bubble (`valid=0`).
- Match for source s:
  - requires `id_rs*_used`, a nonzero address, a valid entry, and `entry.rd == addr`;
  - the youngest matching stage (lowest k) wins.
- Ready stage of an entry: `LOAD_READY` if `is_load`, else `ALU_READY`.
- Hazard on s when the youngest match sits at k < ready stage.
- `stall = id_valid & ~flush & (hazard_rs1 | hazard_rs2)`.
- `fwd_rs*_sel = k` of the youngest match when that match is not hazardous; otherwise 0.
- The register file writes at the end of stage `STAGES` and does not bypass. An entry in stage `STAGES` is therefore a real match.
- The ID instruction's own rd is never compared against its own sources. `lw x10, 4(x10)` stalls only on older producers of x10.
- `flush`:
  - clears all valid bits on the clock edge;
  - forces `stall=0` in that cycle;
  - the ID instruction is not inserted.
- `stall_count` increments on each cycle with `stall=1` and saturates at 16'hFFFF.

## Timing
- `stall` and `fwd_*_sel` are combinational from the ID inputs and the registered entries, with zero-cycle latency.
- Entry state updates only on `posedge clk`.
- Reset: all entries invalid, `stall_count=0`. Consequently `stall=0` and `fwd_*_sel=0` in the cycle after reset.
- `rst` asserted mid-operation overrides `flush` and the shift, and has the same effect as reset.
- With the default parameters, back-to-back load→use costs exactly 2 stall cycles, then forwards from stage 3. ALU→use costs 1 stall, then forwards from stage 2.
- A stall never exceeds `LOAD_READY-1` cycles for one producer, because bubbles advance the producer every cycle.

## Configuration
- `HAZARD_FORWARDING_EN` defined: behaviour as above.
- `HAZARD_FORWARDING_EN` undefined:
  - any match in stages 1..`STAGES` is a hazard;
  - `fwd_*_sel` are tied to 0;
  - load-use and ALU-use both stall until the producer retires (`STAGES` cycles after issue).

## Structure
- `REG_ADDR_WIDTH`, the default stage constants, and the entry field widths go in the shared header `rv32i_params.vh`.
- Sub-module `scoreboard_stage`: one entry register plus its two address comparators, instantiated `STAGES` times via generate.
- The youngest-match priority select lives in the top level.

## Test plan
- Load then dependent `lw x10,4(x10)` preceded by `lw x10,0(x0)`: `stall=1` for 2 cycles, then `fwd_rs1_sel=3`; `stall_count=2`.
- `add x5,x1,x2` then `sub x6,x5,x5`: 1 stall, then `fwd_rs1_sel=fwd_rs2_sel=2`.
- Producers of x7 in stages 2 and 3 simultaneously, consumer reads x7: `fwd_rs1_sel=2` (youngest wins), `stall=0`.
- Destination x0, or `id_rs2_used=0` with a matching address: no stall, select 0.
- Load in stage 1, then `flush` asserted: `stall=0` in that cycle, all entries invalid next cycle, dependent instruction issues with select 0.
- `HAZARD_FORWARDING_EN` undefined, ALU producer then consumer: 3 stall cycles, selects stay 0. Separately, `rst` mid-stall clears `stall_count` to 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared rv32i scoreboard constants: register address width, default stage
// layout, entry format and stall counter width.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int DEF_STAGES     = 3;
   localparam int DEF_ALU_READY  = 2;
   localparam int DEF_LOAD_READY = 3;
   localparam int STALL_CNT_W    = 16;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      is_load;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if
   import hazard_scoreboard_pkg::*;
#(
   parameter int STAGES = DEF_STAGES
);
   localparam int SEL_W = $clog2(STAGES + 1);

   // No valid/ready pair: id_valid qualifies the decode fields every cycle, and
   // stall is the only back-pressure -- while it is high decode holds its instruction.
   logic                   id_valid;
   reg_addr_t              id_rs1_addr;
   reg_addr_t              id_rs2_addr;
   logic                   id_rs1_used;
   logic                   id_rs2_used;
   reg_addr_t              id_rd_addr;
   logic                   id_reg_write;
   logic                   id_mem_read;
   logic                   flush;
   logic                   stall;
   logic [SEL_W-1:0]       fwd_rs1_sel;
   logic [SEL_W-1:0]       fwd_rs2_sel;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             id_rd_addr, id_reg_write, id_mem_read, flush,
      input  stall, fwd_rs1_sel, fwd_rs2_sel, stall_count
   );

   modport slave (
      input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             id_rd_addr, id_reg_write, id_mem_read, flush,
      output stall, fwd_rs1_sel, fwd_rs2_sel, stall_count
   );

endinterface

// File: rtl/hazard_scoreboard_stage.sv
// One in-flight scoreboard entry plus its rs1/rs2 destination comparators.
module hazard_scoreboard_stage
   import hazard_scoreboard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  sb_entry_t entry_in,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   output sb_entry_t entry,
   output logic      rs1_hit,
   output logic      rs2_hit
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         entry <= '0;
      end else begin
         entry <= entry_in;
      end
   end

   assign rs1_hit = entry.valid && (entry.rd == rs1_addr);
   assign rs2_hit = entry.valid && (entry.rd == rs2_addr);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard beside decode: stall, rs1/rs2 forwarding selects, stall counter.
// Forwarding is compiled in with HAZARD_FORWARDING_EN; otherwise any match stalls until retire.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int STAGES     = DEF_STAGES,
   parameter int ALU_READY  = DEF_ALU_READY,
   parameter int LOAD_READY = DEF_LOAD_READY
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave sb
);

   localparam int SEL_W = $clog2(STAGES + 1);
`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   sb_entry_t              stage_in [1:STAGES];
   sb_entry_t              stage_q  [1:STAGES];
   logic [STAGES:1]        rs1_hit;
   logic [STAGES:1]        rs2_hit;
   logic [STAGES:1]        src_hit  [2];
   reg_addr_t              src_addr [2];
   logic [1:0]             src_used;
   logic [1:0]             hazard;
   logic [SEL_W-1:0]       fwd_sel  [2];
   logic                   stall;
   logic [STALL_CNT_W-1:0] stall_count;

   // A stalled or killed ID instruction enters EX as a bubble; x0 writes never track.
   always_comb begin
      stage_in[1]         = '0;
      stage_in[1].valid   = sb.id_valid && !stall && sb.id_reg_write && (sb.id_rd_addr != '0);
      stage_in[1].rd      = sb.id_rd_addr;
      stage_in[1].is_load = sb.id_mem_read;
   end

   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      if (k > 1) begin : g_shift
         assign stage_in[k] = stage_q[k-1];
      end
      hazard_scoreboard_stage u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (sb.flush),
         .entry_in (stage_in[k]),
         .rs1_addr (sb.id_rs1_addr),
         .rs2_addr (sb.id_rs2_addr),
         .entry    (stage_q[k]),
         .rs1_hit  (rs1_hit[k]),
         .rs2_hit  (rs2_hit[k])
      );
   end

   assign src_hit[0]  = rs1_hit;
   assign src_hit[1]  = rs2_hit;
   assign src_addr[0] = sb.id_rs1_addr;
   assign src_addr[1] = sb.id_rs2_addr;
   assign src_used    = {sb.id_rs2_used, sb.id_rs1_used};

   for (genvar s = 0; s < 2; s++) begin : g_src
      logic             any_hit;
      logic             young_ld;
      logic [SEL_W-1:0] young_k;
      logic             early;

      // Scan oldest to youngest so the lowest matching stage is the last write.
      always_comb begin
         any_hit  = 1'b0;
         young_ld = 1'b0;
         young_k  = '0;
         for (int k = STAGES; k >= 1; k--) begin
            if (src_used[s] && (src_addr[s] != '0) && src_hit[s][k]) begin
               any_hit  = 1'b1;
               young_ld = stage_q[k].is_load;
               young_k  = SEL_W'(k);
            end
         end
      end

      assign early      = int'(young_k) < (young_ld ? LOAD_READY : ALU_READY);
      assign hazard[s]  = any_hit && (early || !FWD_EN);
      assign fwd_sel[s] = (FWD_EN && any_hit && !early) ? young_k : '0;
   end

   assign stall = sb.id_valid && !sb.flush && (|hazard);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign sb.stall       = stall;
   assign sb.fwd_rs1_sel = fwd_sel[0];
   assign sb.fwd_rs2_sel = fwd_sel[1];
   assign sb.stall_count = stall_count;

endmodule
